// File: rtl/segment7_decoder.sv
// segment7_decoder: registered hex to seven-segment decoder.
// The code register captures bcd when en=1. The segment outputs are registered
// and update on every edge. Lamp test, blanking and ripple-blank zero
// suppression are applied in that priority order. SEG_ACTIVE_LOW selects
// common-anode drive.
// Optional decimal point: define SEGMENT7_DP_EN to add dp_in/dp.
// Segment bit order: bit0=a ... bit6=g.
module segment7_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] bcd,
   input  logic       en,
   input  logic       blank,
   input  logic       lamp_test,
   input  logic       rbi,
`ifdef SEGMENT7_DP_EN
   input  logic       dp_in,
   output logic       dp,
`endif
   output logic [6:0] seg,
   output logic       rbo
);

   // XOR mask applied after the priority logic; all ones for common-anode drive.
   localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

   logic [3:0] code_q;
   logic [3:0] code_d;
   logic [6:0] seg_d;
   logic       rbo_d;

   // Active-high segment pattern for each of the 16 codes.
   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] pattern;
      case (code)
         4'h0: pattern = 7'h3F;
         4'h1: pattern = 7'h06;
         4'h2: pattern = 7'h5B;
         4'h3: pattern = 7'h4F;
         4'h4: pattern = 7'h66;
         4'h5: pattern = 7'h6D;
         4'h6: pattern = 7'h7D;
         4'h7: pattern = 7'h07;
         4'h8: pattern = 7'h7F;
         4'h9: pattern = 7'h6F;
         4'hA: pattern = 7'h77;
         4'hB: pattern = 7'h7C;
         4'hC: pattern = 7'h39;
         4'hD: pattern = 7'h5E;
         4'hE: pattern = 7'h79;
         default: pattern = 7'h71;
      endcase
      return pattern;
   endfunction

   // Next code value and prioritised active-high segment/ripple-blank outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      code_d = en ? bcd : code_q;
      seg_d  = decode(code_d);
      rbo_d  = 1'b0;
      if (lamp_test) begin
         seg_d = 7'h7F;
      end else if (blank) begin
         seg_d = 7'h00;
      end else if (rbi && (code_d == 4'h0)) begin
         seg_d = 7'h00;
         rbo_d = 1'b1;
      end
   end

   // Code and output registers; reset blanks the display and clears the code.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         code_q <= 4'h0;
         seg    <= SEG_POL;
         rbo    <= 1'b0;
      end else begin
         code_q <= code_d;
         seg    <= seg_d ^ SEG_POL;
         rbo    <= rbo_d;
      end
   end

`ifdef SEGMENT7_DP_EN
   logic dp_q;
   logic dp_d;
   logic dp_out_d;

   // The decimal point follows bcd's en gating and is immune to ripple blanking.
   always_comb begin
      dp_d     = en ? dp_in : dp_q;
      dp_out_d = dp_d;
      if (lamp_test) begin
         dp_out_d = 1'b1;
      end else if (blank) begin
         dp_out_d = 1'b0;
      end
   end

   // Decimal point registers, reset to off in the selected polarity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dp_q <= 1'b0;
         dp   <= SEG_ACTIVE_LOW;
      end else begin
         dp_q <= dp_d;
         dp   <= dp_out_d ^ SEG_ACTIVE_LOW;
      end
   end
`endif

endmodule

// File: tb/tb_segment7_decoder.sv
// tb_segment7_decoder: directed scoreboard bench for segment7_decoder.
// Two instances share every input: one active-high and one with SEG_ACTIVE_LOW=1.
// Expected values come from the decode table and the priority rules.
// When SEGMENT7_DP_EN is defined, dp is also compared on both instances.
module tb_segment7_decoder;

   logic       clk;
   logic       rst_n;
   logic [3:0] bcd;
   logic       en;
   logic       blank;
   logic       lamp_test;
   logic       rbi;
   logic       dp_in;
   logic [6:0] seg_h;
   logic [6:0] seg_l;
   logic       rbo_h;
   logic       rbo_l;
`ifdef SEGMENT7_DP_EN
   logic       dp_h;
   logic       dp_l;
`endif

   typedef struct {
      string      tag;
      logic [6:0] seg;
      logic       rbo;
      logic       dp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic dp_ref = 1'b0;

   segment7_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .blank(blank),
      .lamp_test(lamp_test), .rbi(rbi),
`ifdef SEGMENT7_DP_EN
      .dp_in(dp_in), .dp(dp_h),
`endif
      .seg(seg_h), .rbo(rbo_h)
   );

   segment7_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .blank(blank),
      .lamp_test(lamp_test), .rbi(rbi),
`ifdef SEGMENT7_DP_EN
      .dp_in(dp_in), .dp(dp_l),
`endif
      .seg(seg_l), .rbo(rbo_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog against a run that never reaches its summary.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   // Pop one expectation and compare it against both instances.
   task automatic check_out();
      exp_t x;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_bad++;
         $error("FAIL scoreboard: observed empty queue, expected an entry");
      end
      if (sb.size() != 0) begin
         x = sb.pop_front();
         n_cmp++;
         assert (seg_h === x.seg) else begin
            n_bad++;
            $error("FAIL %s seg(high): observed %h expected %h", x.tag, seg_h, x.seg);
         end
         n_cmp++;
         assert (rbo_h === x.rbo) else begin
            n_bad++;
            $error("FAIL %s rbo(high): observed %b expected %b", x.tag, rbo_h, x.rbo);
         end
         n_cmp++;
         assert (seg_l === ~x.seg) else begin
            n_bad++;
            $error("FAIL %s seg(low): observed %h expected %h", x.tag, seg_l, ~x.seg);
         end
         n_cmp++;
         assert (rbo_l === x.rbo) else begin
            n_bad++;
            $error("FAIL %s rbo(low): observed %b expected %b", x.tag, rbo_l, x.rbo);
         end
`ifdef SEGMENT7_DP_EN
         n_cmp++;
         assert (dp_h === x.dp) else begin
            n_bad++;
            $error("FAIL %s dp(high): observed %b expected %b", x.tag, dp_h, x.dp);
         end
         n_cmp++;
         assert (dp_l === ~x.dp) else begin
            n_bad++;
            $error("FAIL %s dp(low): observed %b expected %b", x.tag, dp_l, ~x.dp);
         end
`endif
      end
   endtask

   // Drive one cycle of inputs, push the active-high expectation, clock, compare.
   task automatic step(input string tag, input logic r, input logic [3:0] b,
                       input logic e, input logic bl, input logic lt,
                       input logic rb, input logic dpi,
                       input logic [6:0] exp_seg, input logic exp_rbo);
      exp_t x;
      rst_n     = r;
      bcd       = b;
      en        = e;
      blank     = bl;
      lamp_test = lt;
      rbi       = rb;
      dp_in     = dpi;
      if (!r)     dp_ref = 1'b0;
      else if (e) dp_ref = dpi;
      x.tag = tag;
      x.seg = exp_seg;
      x.rbo = exp_rbo;
      x.dp  = !r ? 1'b0 : lt ? 1'b1 : bl ? 1'b0 : dp_ref;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      logic [6:0] tbl [16];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      // Reset held for two edges overrides en/bcd, then the first loaded code appears.
      step("reset0",  1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      step("reset1",  1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      step("release", 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h6D, 1'b0);

      // Full table sweep, one code per cycle.
      for (int i = 0; i < 16; i++) begin
         step($sformatf("sweep%0d", i), 1'b1, i[3:0], 1'b1, 1'b0, 1'b0, 1'b0,
              i[0], tbl[i], 1'b0);
      end

      // Hold, then lamp test over the held code, then release.
      step("load3",    1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h4F, 1'b0);
      step("hold3",    1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h4F, 1'b0);
      step("lamp",     1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h7F, 1'b0);
      step("lamp_rel", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h4F, 1'b0);

      // Ripple-blank zero suppression.
      step("rb_zero",  1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'h00, 1'b1);
      step("rb_held",  1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1);
      step("zero_nrb", 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h3F, 1'b0);
      step("rb_seven", 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'h07, 1'b0);
      step("lamp_rb0", 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b0);
      step("blank_rb0",1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0);

      // Priority between lamp test and blanking; held code returns after blanking.
      step("lamp_blank", 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h7F, 1'b0);
      step("blank8",     1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      step("unblank8",   1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b0);

      // Reset mid-display, then resume with en low: code 0 decodes as 3F.
      step("mid_reset", 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      step("resume0",   1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'h3F, 1'b0);
      step("resumeA",   1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h77, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
